i2c_host_ctrl: RTL and testbench

Single-master I2C controller that issues one-byte register reads and writes to the on-chip I2C_trx responder, or to any 7-bit-addressed device using 8-bit register addressing. It accepts a command through a valid/ready handshake and generates START, address, register, data, ACK/NACK, repeated-START and STOP on open-drain SCL/SDA. It returns the read data and an ACK status. In the system it drives the shared wired-AND Pad_SCL/Pad_SDA nets, taking the role the host tasks take in the existing bench.

---
 rtl/i2c_host_ctrl.sv | 271 +++++++++++++++++++++++++++
 tb/tb_i2c_host_ctrl.sv | 301 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/i2c_host_ctrl.sv
// i2c_host_ctrl: single-master I2C controller issuing one-byte register
// reads and writes (8-bit register address) to a 7-bit-addressed target.
module i2c_host_ctrl #(
    parameter int unsigned CLK_DIV  = 125,
    parameter logic [6:0]  SLV_ADDR = 7'h50
) (
    input  logic       clk_50M,
    input  logic       rst_n,
    input  logic       cmd_valid,
    output logic       cmd_ready,
    input  logic       cmd_rw,
    input  logic [7:0] cmd_addr,
    input  logic [7:0] cmd_wdata,
    output logic       rsp_valid,
    output logic [7:0] rsp_rdata,
    output logic       rsp_nack,
    output logic       busy,
    output logic       SCL_out,
    output logic       SDA_out,
    input  logic       SDA_in
);

    localparam int unsigned DIV_W = $clog2(CLK_DIV);
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);

    // Which byte of the sequence is currently on the wire
    localparam logic [1:0] B_ADDR_W = 2'd0;
    localparam logic [1:0] B_REG    = 2'd1;
    localparam logic [1:0] B_WDATA  = 2'd2;
    localparam logic [1:0] B_ADDR_R = 2'd3;

    typedef enum logic [3:0] {
        IDLE, START, TX_BYTE, RX_ACK, RSTART, RX_BYTE, TX_NACK, STOP, DONE
    } state_t;

    state_t           state_q, state_d;
    logic [DIV_W-1:0] div_q, div_d;
    logic [1:0]       qtr_q, qtr_d;
    logic [2:0]       bit_q, bit_d;
    logic [7:0]       shift_q, shift_d;
    logic [1:0]       byte_q, byte_d;
    logic             rw_q, rw_d;
    logic [7:0]       addr_q, addr_d;
    logic [7:0]       wdata_q, wdata_d;
    logic             ack_q, ack_d;
    logic             cmd_ready_q, cmd_ready_d;
    logic             busy_q, busy_d;
    logic             rsp_valid_q, rsp_valid_d;
    logic [7:0]       rsp_rdata_q, rsp_rdata_d;
    logic             rsp_nack_q, rsp_nack_d;
    logic             scl_q, scl_d;
    logic             sda_q, sda_d;

    logic accept;
    logic tick;
    logic qtr_end;
    logic sample;

    assign accept  = cmd_valid & cmd_ready_q;
    assign tick    = (div_q == DIV_LAST);
    assign qtr_end = tick && (qtr_q == 2'd3);
    assign sample  = tick && (qtr_q == 2'd2);

    assign cmd_ready = cmd_ready_q;
    assign busy      = busy_q;
    assign rsp_valid = rsp_valid_q;
    assign rsp_rdata = rsp_rdata_q;
    assign rsp_nack  = rsp_nack_q;
    assign SCL_out   = scl_q;
    assign SDA_out   = sda_q;

    // State and datapath registers; reset releases both bus lines at once
    always_ff @(posedge clk_50M or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            div_q       <= '0;
            qtr_q       <= 2'd0;
            bit_q       <= 3'd0;
            shift_q     <= 8'd0;
            byte_q      <= B_ADDR_W;
            rw_q        <= 1'b0;
            addr_q      <= 8'd0;
            wdata_q     <= 8'd0;
            ack_q       <= 1'b0;
            cmd_ready_q <= 1'b1;
            busy_q      <= 1'b0;
            rsp_valid_q <= 1'b0;
            rsp_rdata_q <= 8'd0;
            rsp_nack_q  <= 1'b0;
            scl_q       <= 1'b1;
            sda_q       <= 1'b1;
        end else begin
            state_q     <= state_d;
            div_q       <= div_d;
            qtr_q       <= qtr_d;
            bit_q       <= bit_d;
            shift_q     <= shift_d;
            byte_q      <= byte_d;
            rw_q        <= rw_d;
            addr_q      <= addr_d;
            wdata_q     <= wdata_d;
            ack_q       <= ack_d;
            cmd_ready_q <= cmd_ready_d;
            busy_q      <= busy_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_rdata_q <= rsp_rdata_d;
            rsp_nack_q  <= rsp_nack_d;
            scl_q       <= scl_d;
            sda_q       <= sda_d;
        end
    end

    // Next-state, quarter timing, shifting and registered output levels
    always_comb begin
        state_d     = state_q;
        div_d       = div_q;
        qtr_d       = qtr_q;
        bit_d       = bit_q;
        shift_d     = shift_q;
        byte_d      = byte_q;
        rw_d        = rw_q;
        addr_d      = addr_q;
        wdata_d     = wdata_q;
        ack_d       = ack_q;
        rsp_valid_d = 1'b0;
        rsp_rdata_d = rsp_rdata_q;
        rsp_nack_d  = rsp_nack_q;
        scl_d       = 1'b1;
        sda_d       = 1'b1;

        if (state_q != IDLE) begin
            div_d = tick ? '0 : div_q + DIV_W'(1);
            if (tick) begin
                qtr_d = qtr_q + 2'd1;
            end
        end

        unique case (state_q)
            IDLE: begin
                if (accept) begin
                    state_d     = START;
                    div_d       = '0;
                    qtr_d       = 2'd0;
                    rw_d        = cmd_rw;
                    addr_d      = cmd_addr;
                    wdata_d     = cmd_wdata;
                    rsp_rdata_d = 8'd0;
                    rsp_nack_d  = 1'b0;
                end
            end
            START: begin
                if (qtr_end) begin
                    state_d = TX_BYTE;
                    shift_d = {SLV_ADDR, 1'b0};
                    bit_d   = 3'd7;
                    byte_d  = B_ADDR_W;
                end
            end
            TX_BYTE: begin
                if (qtr_end) begin
                    if (bit_q == 3'd0) begin
                        state_d = RX_ACK;
                    end else begin
                        shift_d = {shift_q[6:0], 1'b0};
                        bit_d   = bit_q - 3'd1;
                    end
                end
            end
            RX_ACK: begin
                if (sample) begin
                    ack_d = SDA_in;
                end
                if (qtr_end) begin
                    bit_d = 3'd7;
                    if (ack_q) begin
                        rsp_nack_d = 1'b1;
                        state_d    = STOP;
                    end else begin
                        unique case (byte_q)
                            B_ADDR_W: begin
                                state_d = TX_BYTE;
                                shift_d = addr_q;
                                byte_d  = B_REG;
                            end
                            B_REG: begin
                                if (rw_q) begin
                                    state_d = RSTART;
                                end else begin
                                    state_d = TX_BYTE;
                                    shift_d = wdata_q;
                                    byte_d  = B_WDATA;
                                end
                            end
                            B_WDATA:  state_d = STOP;
                            B_ADDR_R: state_d = RX_BYTE;
                            default:  state_d = STOP;
                        endcase
                    end
                end
            end
            RSTART: begin
                if (qtr_end) begin
                    state_d = TX_BYTE;
                    shift_d = {SLV_ADDR, 1'b1};
                    bit_d   = 3'd7;
                    byte_d  = B_ADDR_R;
                end
            end
            RX_BYTE: begin
                if (sample) begin
                    shift_d = {shift_q[6:0], SDA_in};
                end
                if (qtr_end) begin
                    if (bit_q == 3'd0) begin
                        state_d = TX_NACK;
                    end else begin
                        bit_d = bit_q - 3'd1;
                    end
                end
            end
            TX_NACK: begin
                if (qtr_end) begin
                    state_d = STOP;
                end
            end
            STOP: begin
                if (qtr_end) begin
                    state_d = DONE;
                end
            end
            DONE: begin
                state_d     = IDLE;
                rsp_valid_d = 1'b1;
                rsp_rdata_d = (rw_q && !rsp_nack_q) ? shift_q : 8'd0;
            end
            default: state_d = IDLE;
        endcase

        // Line levels for the quarter that begins after this edge
        unique case (state_d)
            START: begin
                scl_d = (qtr_d != 2'd3);
                sda_d = (qtr_d < 2'd2);
            end
            TX_BYTE: begin
                scl_d = qtr_d[0] ^ qtr_d[1];
                sda_d = shift_d[7];
            end
            RX_ACK, RX_BYTE, TX_NACK: begin
                scl_d = qtr_d[0] ^ qtr_d[1];
                sda_d = 1'b1;
            end
            RSTART: begin
                scl_d = qtr_d[0] ^ qtr_d[1];
                sda_d = (qtr_d < 2'd2);
            end
            STOP: begin
                scl_d = (qtr_d != 2'd0);
                sda_d = (qtr_d >= 2'd2);
            end
            default: begin
                scl_d = 1'b1;
                sda_d = 1'b1;
            end
        endcase
    end

    assign cmd_ready_d = (state_d == IDLE) && (state_q != DONE);
    assign busy_d      = (state_d != IDLE);

endmodule

// File: tb/tb_i2c_host_ctrl.sv
// tb_i2c_host_ctrl: bench for i2c_host_ctrl with a behavioural I2C
// register responder on a wired-AND SDA line.
module tb_i2c_host_ctrl;

    localparam int unsigned CLK_DIV = 4;
    localparam logic [6:0]  SLV     = 7'h50;
    localparam int WR_CYC = 116 * CLK_DIV + 1;
    localparam int RD_CYC = 156 * CLK_DIV + 1;
    localparam int NK_CYC = 44 * CLK_DIV + 1;

    logic       clk_50M   = 1'b0;
    logic       rst_n     = 1'b1;
    logic       cmd_valid = 1'b0;
    logic       cmd_rw    = 1'b0;
    logic [7:0] cmd_addr  = 8'd0;
    logic [7:0] cmd_wdata = 8'd0;
    logic       cmd_ready, rsp_valid, rsp_nack, busy, SCL_out, SDA_out;
    logic [7:0] rsp_rdata;
    logic       slv_sda = 1'b1;
    logic       sda_line;

    assign sda_line = SDA_out & slv_sda;

    i2c_host_ctrl #(.CLK_DIV(CLK_DIV), .SLV_ADDR(SLV)) dut (
        .clk_50M(clk_50M), .rst_n(rst_n), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
        .cmd_rw(cmd_rw), .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata),
        .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_nack(rsp_nack), .busy(busy),
        .SCL_out(SCL_out), .SDA_out(SDA_out), .SDA_in(sda_line)
    );

    always #10 clk_50M = ~clk_50M;

    int n_cmp = 0;
    int n_bad = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
        end
    endtask

    // Responder: register file reached through {addr, ptr, data} writes and
    // {addr, ptr, rSTART, addr|1, data} reads; also logs every bit clocked on SCL
    logic [7:0] s_mem [0:255];
    logic [7:0] s_byte, s_ptr, s_tx;
    int         s_bits, s_nbyte;
    bit         s_sel, s_rd, s_rd_next;
    bit         resp_en = 1'b1;
    logic       m_prev_scl = 1'b1, m_prev_sda = 1'b1;
    bit         stream [$];
    bit         exp_q  [$];
    int         n_start, n_stop;

    always @(negedge clk_50M) begin
        if (!rst_n) begin
            slv_sda = 1'b1; s_bits = 0; s_nbyte = 0;
            s_sel = 1'b0; s_rd = 1'b0; s_rd_next = 1'b0;
            m_prev_scl = 1'b1; m_prev_sda = 1'b1;
        end else begin
            if (SCL_out && m_prev_scl && (sda_line != m_prev_sda)) begin
                if (!sda_line) begin n_start++; s_sel = 1'b1; end
                else begin n_stop++; s_sel = 1'b0; end
                s_bits = 0; s_nbyte = 0; s_rd = 1'b0; s_rd_next = 1'b0; slv_sda = 1'b1;
            end else if (SCL_out && !m_prev_scl) begin
                stream.push_back(sda_line);
                if (s_bits < 8) begin
                    s_byte = {s_byte[6:0], sda_line};
                    s_bits++;
                end else begin
                    if (s_rd && sda_line) begin s_rd = 1'b0; s_sel = 1'b0; end
                    s_bits = 9;
                end
            end else if (!SCL_out && m_prev_scl) begin
                if (s_bits == 8) begin
                    slv_sda = 1'b1;
                    if (!s_rd && s_sel && resp_en) begin
                        if (s_nbyte == 0) begin
                            if (s_byte[7:1] == SLV) begin slv_sda = 1'b0; s_rd_next = s_byte[0]; end
                            else s_sel = 1'b0;
                        end else if (s_nbyte == 1) begin
                            s_ptr = s_byte; slv_sda = 1'b0;
                        end else begin
                            s_mem[s_ptr] = s_byte; s_ptr = s_ptr + 8'd1; slv_sda = 1'b0;
                        end
                    end
                end else if (s_bits == 9) begin
                    slv_sda = 1'b1; s_bits = 0; s_nbyte++;
                    if (s_rd_next) begin s_rd = 1'b1; s_rd_next = 1'b0; s_tx = s_mem[s_ptr]; end
                end
                if (s_rd && s_bits < 8) slv_sda = s_tx[7 - s_bits];
            end
            m_prev_scl = SCL_out;
            m_prev_sda = SDA_out & slv_sda;
        end
    end

    // Reference bus bit sequence: every SDA level seen on an SCL rising edge
    task automatic push_byte(input logic [7:0] b);
        for (int i = 7; i >= 0; i--) exp_q.push_back(b[i]);
    endtask

    task automatic build_exp(input bit rw, input logic [7:0] addr, input logic [7:0] wdata,
                             input logic [7:0] rdata, input bit present);
        exp_q.delete();
        push_byte({SLV, 1'b0});
        exp_q.push_back(!present);
        if (present) begin
            push_byte(addr); exp_q.push_back(1'b0);
            if (!rw) begin
                push_byte(wdata); exp_q.push_back(1'b0);
            end else begin
                exp_q.push_back(1'b1);            // SCL rise of the repeated START
                push_byte({SLV, 1'b1}); exp_q.push_back(1'b0);
                push_byte(rdata); exp_q.push_back(1'b1);  // host NACK
            end
        end
        exp_q.push_back(1'b0);                    // SCL rise inside STOP, SDA still low
    endtask

    // Issue one command and time it from the accept edge to rsp_valid
    task automatic run_cmd(input bit rw, input logic [7:0] addr, input logic [7:0] wdata,
                           input bit hold, output logic [7:0] rd, output logic [7:0] rd_late,
                           output bit nk, output int cyc, output bit ok);
        int guard;
        int hs_bad;
        guard = 0; hs_bad = 0; ok = 1'b0; rd = 8'd0; rd_late = 8'd0; nk = 1'b0; cyc = 0;
        @(negedge clk_50M);
        while (!cmd_ready && guard < 2000) begin @(negedge clk_50M); guard++; end
        if (!cmd_ready) begin
            n_cmp++; n_bad++;
            $display("FAIL ready_wait: cmd_ready=0 after %0d cycles, want 1", guard);
            return;
        end
        cmd_valid = 1'b1; cmd_rw = rw; cmd_addr = addr; cmd_wdata = wdata;
        @(posedge clk_50M); #1;
        stream.delete(); n_start = 0; n_stop = 0;
        if (!hold) cmd_valid = 1'b0;
        while (!rsp_valid && cyc < 3000) begin
            if (hold) begin
                cmd_rw = 1'($urandom); cmd_addr = 8'($urandom); cmd_wdata = 8'($urandom);
            end
            @(posedge clk_50M); #1; cyc++;
            if (!rsp_valid && (cmd_ready || !busy)) hs_bad++;
        end
        cmd_valid = 1'b0;
        if (!rsp_valid) begin
            n_cmp++; n_bad++;
            $display("FAIL rsp_timeout: rsp_valid=0 after %0d cycles, want 1", cyc);
            return;
        end
        rd = rsp_rdata; nk = rsp_nack; ok = 1'b1;
        check("handshake_busy", 32'(hs_bad), 32'd0);
        check("ready_at_rsp", 32'(cmd_ready), 32'd0);
        @(posedge clk_50M); #1;
        check("rsp_pulse_width", 32'(rsp_valid), 32'd0);
        check("ready_after_rsp", 32'(cmd_ready), 32'd1);
        rd_late = rsp_rdata;
    endtask

    task automatic exec(input string tag, input bit rw, input logic [7:0] addr,
                        input logic [7:0] wdata, input bit present, input bit hold,
                        input logic [7:0] exp_rdata, input bit exp_nack, input int exp_cyc);
        logic [7:0] rd, rd_late;
        bit nk, ok;
        int cyc, diff;
        resp_en = present;
        run_cmd(rw, addr, wdata, hold, rd, rd_late, nk, cyc, ok);
        if (!ok) return;
        check({tag, ":cycles"}, 32'(cyc), 32'(exp_cyc));
        check({tag, ":nack"}, 32'(nk), 32'(exp_nack));
        if (rw) begin
            check({tag, ":rdata"}, 32'(rd), 32'(exp_rdata));
            check({tag, ":rdata_held"}, 32'(rd_late), 32'(exp_rdata));
        end
        build_exp(rw, addr, wdata, exp_rdata, present);
        diff = 0;
        for (int i = 0; i < stream.size() && i < exp_q.size(); i++)
            if (stream[i] != exp_q[i]) diff++;
        check({tag, ":stream_len"}, 32'(stream.size()), 32'(exp_q.size()));
        check({tag, ":stream_bits"}, 32'(diff), 32'd0);
        check({tag, ":starts"}, 32'(n_start), (rw && present) ? 32'd2 : 32'd1);
        check({tag, ":stops"}, 32'(n_stop), 32'd1);
    endtask

    typedef struct {
        bit         rw;
        logic [7:0] addr;
        logic [7:0] wdata;
        bit         present;
        logic [7:0] exp_rdata;
        bit         exp_nack;
        int         exp_cyc;
    } vec_t;

    function automatic vec_t mk(bit rw, logic [7:0] addr, logic [7:0] wdata, bit present,
                                logic [7:0] exp_rdata, bit exp_nack, int exp_cyc);
        vec_t v;
        v.rw = rw; v.addr = addr; v.wdata = wdata; v.present = present;
        v.exp_rdata = exp_rdata; v.exp_nack = exp_nack; v.exp_cyc = exp_cyc;
        return v;
    endfunction

    logic [7:0] sb [0:255];
    vec_t       tbl [$];

    initial begin
        for (int i = 0; i < 256; i++) begin s_mem[i] = 8'hFF; sb[i] = 8'hFF; end

        // Reset values
        #2 rst_n = 1'b0;
        #100;
        check("rst:SCL_out", 32'(SCL_out), 32'd1);
        check("rst:SDA_out", 32'(SDA_out), 32'd1);
        check("rst:cmd_ready", 32'(cmd_ready), 32'd1);
        check("rst:busy", 32'(busy), 32'd0);
        check("rst:rsp_valid", 32'(rsp_valid), 32'd0);
        check("rst:rsp_rdata", 32'(rsp_rdata), 32'd0);
        check("rst:rsp_nack", 32'(rsp_nack), 32'd0);
        @(negedge clk_50M) rst_n = 1'b1;
        repeat (3) @(negedge clk_50M);

        // Directed table
        tbl.push_back(mk(1'b0, 8'h03, 8'hA5, 1'b1, 8'h00, 1'b0, WR_CYC));
        tbl.push_back(mk(1'b1, 8'h03, 8'h00, 1'b1, 8'hA5, 1'b0, RD_CYC));
        for (int i = 0; i < 8; i++)
            tbl.push_back(mk(1'b0, 8'(i), 8'(i + 8), 1'b1, 8'h00, 1'b0, WR_CYC));
        for (int i = 0; i < 8; i++)
            tbl.push_back(mk(1'b1, 8'(i), 8'h00, 1'b1, 8'(i + 8), 1'b0, RD_CYC));
        tbl.push_back(mk(1'b1, 8'h05, 8'h00, 1'b0, 8'h00, 1'b1, NK_CYC));
        tbl.push_back(mk(1'b0, 8'h06, 8'h77, 1'b0, 8'h00, 1'b1, NK_CYC));
        tbl.push_back(mk(1'b1, 8'h06, 8'h00, 1'b1, 8'h0E, 1'b0, RD_CYC));
        tbl.push_back(mk(1'b1, 8'h40, 8'h00, 1'b1, 8'hFF, 1'b0, RD_CYC));
        foreach (tbl[k]) begin
            exec($sformatf("tbl%0d", k), tbl[k].rw, tbl[k].addr, tbl[k].wdata, tbl[k].present,
                 1'b0, tbl[k].exp_rdata, tbl[k].exp_nack, tbl[k].exp_cyc);
            if (!tbl[k].rw && tbl[k].present) sb[tbl[k].addr] = tbl[k].wdata;
        end

        // cmd_valid held and inputs scrambled through a busy write
        begin
            int extra;
            exec("hold_wr", 1'b0, 8'h0A, 8'h3C, 1'b1, 1'b1, 8'h00, 1'b0, WR_CYC);
            sb[8'h0A] = 8'h3C;
            extra = 0;
            repeat (20) begin
                @(posedge clk_50M); #1;
                if (busy || rsp_valid) extra++;
            end
            check("hold:no_queued_cmd", 32'(extra), 32'd0);
            exec("hold_rd", 1'b1, 8'h0A, 8'h00, 1'b1, 1'b0, 8'h3C, 1'b0, RD_CYC);
        end

        // Reset in the middle of the data byte of a read
        begin
            int guard;
            guard = 0;
            resp_en = 1'b1;
            @(negedge clk_50M);
            while (!cmd_ready && guard < 2000) begin @(negedge clk_50M); guard++; end
            cmd_valid = 1'b1; cmd_rw = 1'b1; cmd_addr = 8'h03; cmd_wdata = 8'h00;
            @(posedge clk_50M); #1;
            cmd_valid = 1'b0;
            repeat (481) @(posedge clk_50M);
            #1;
            check("midrst:scl_low_in_rx", 32'(SCL_out), 32'd0);
            check("midrst:busy_before", 32'(busy), 32'd1);
            #2 rst_n = 1'b0;
            #1;
            check("midrst:SCL_released", 32'(SCL_out), 32'd1);
            check("midrst:SDA_released", 32'(SDA_out), 32'd1);
            check("midrst:cmd_ready", 32'(cmd_ready), 32'd1);
            check("midrst:busy", 32'(busy), 32'd0);
            repeat (2) @(negedge clk_50M);
            rst_n = 1'b1;
            repeat (2) @(negedge clk_50M);
            exec("post_rst_wr", 1'b0, 8'h0B, 8'h5A, 1'b1, 1'b0, 8'h00, 1'b0, WR_CYC);
            sb[8'h0B] = 8'h5A;
            exec("post_rst_rd", 1'b1, 8'h0B, 8'h00, 1'b1, 1'b0, 8'h5A, 1'b0, RD_CYC);
        end

        // Randomised traffic against a scoreboard of the responder's registers
        for (int n = 0; n < 16; n++) begin
            bit         rw, present;
            logic [7:0] addr, wdata, erd;
            rw      = 1'($urandom);
            addr    = 8'($urandom_range(0, 15));
            wdata   = 8'($urandom);
            present = ($urandom_range(0, 7) != 0);
            erd     = (rw && present) ? sb[addr] : 8'h00;
            exec($sformatf("rnd%0d", n), rw, addr, wdata, present, 1'b0, erd, !present,
                 !present ? NK_CYC : (rw ? RD_CYC : WR_CYC));
            if (!rw && present) sb[addr] = wdata;
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
